// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the register file and the rest of the pipeline.
// Contents:
//   REG_ADDR_W  register address width (5 bits, 32 architectural registers)
//   REG_DATA_W  register word width (32 bits)
//   REG_ZERO    address of the hardwired $zero register
//   reg_addr_t  register address type
//   reg_data_t  register data type
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/reg_file_word.sv
// One storage word of the register file.
// The word loads wr_data on a clock edge while wr_en is high. Otherwise it
// holds its value. An asynchronous active-low clear forces the word to zero.
// Ports:
//   clk      in   1       clock, updates on posedge
//   reset    in   1       asynchronous clear, active-low
//   wr_en    in   1       word-level write enable (already decoded)
//   wr_data  in   DATA_W  value to store
//   rd_data  out  DATA_W  current stored value
module reg_file_word #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule : reg_file_word

// File: rtl/reg_file.sv
// MIPS general-purpose register file.
// It has one synchronous write port, used by write-back, and two
// combinational read ports (rs and rt), used by decode. Address 0 ($zero)
// has no storage and always reads as zero.
// Optional feature macro: WRITE_BYPASS_EN. When it is defined, a write in
// the current cycle is forwarded to a read port that addresses the same
// register (write-first).
// Ports:
//   clk        in   1       clock, updates on posedge
//   reset      in   1       asynchronous reset, active-low; clears every word
//   wr_en      in   1       write strobe (RegWrite)
//   wr_addr    in   ADDR_W  destination register
//   wr_data    in   DATA_W  write-back value
//   rd_addr_a  in   ADDR_W  read port A address (rs)
//   rd_data_a  out  DATA_W  read port A data
//   rd_addr_b  in   ADDR_W  read port B address (rt)
//   rd_data_b  out  DATA_W  read port B data
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    // Slot 0 is a constant zero. Every other slot is backed by a storage word.
    logic [NUM_REGS-1:0][DATA_W-1:0] words;

    assign words[0] = '0;

    // The one-hot write decode never selects slot 0, so a write to $zero is dropped.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        logic word_we;

        assign word_we = wr_en && (wr_addr == ADDR_W'(i));

        reg_file_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (word_we),
            .wr_data (wr_data),
            .rd_data (words[i])
        );
    end

`ifdef WRITE_BYPASS_EN
    logic wr_live;

    assign wr_live = wr_en && (wr_addr != ADDR_ZERO);
`endif

    always_comb begin
        rd_data_a = words[rd_addr_a];
        rd_data_b = words[rd_addr_b];
`ifdef WRITE_BYPASS_EN
        // Write-first forwarding closes the WB->ID hazard inside the file.
        if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
`endif
        // Reset dominates forwarding as well as storage.
        if (!reset) begin
            rd_data_a = '0;
            rd_data_b = '0;
        end
    end

endmodule : reg_file
